// File: rtl/nexys_starship_ssd_scanner.sv
// Purpose : time-multiplexed seven-segment scan controller with frame-synchronous shadow load,
//           per-digit blank/blink and PWM brightness.
// Latency : An/Cathodes are registered, one Clk behind the internal scan state; frame_done follows the wrap by one Clk.
// Backpressure: none; free-running scan, inputs are sampled only at frame boundaries (brightness is sampled live).
//
// Ports:
//   Clk, Reset        clock and asynchronous active-high reset
//   digits_in         hex nibble per digit, digit k = [4k+3:4k]
//   dp_in/blank_in/blink_in  per-digit decimal point / force dark / blink enable
//   brightness        PWM duty select, 0 = dark, all-ones = full on
//   update_en         reload shadow registers at the next frame boundary
//   An                active-low anodes, Cathodes = {Ca..Cg,Dp} active-low
//   digit_idx         digit currently in its slot, frame_done = pulse after the last slot
module nexys_starship_ssd_scanner #(
    parameter int N_DIGITS     = 8,
    parameter int CLK_DIV_BITS = 14,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_BITS   = 25
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    update_en,
    output logic [N_DIGITS-1:0]     An,
    output logic [7:0]              Cathodes,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    logic [CLK_DIV_BITS-1:0] prescaler;
    logic [BLINK_BITS-1:0]   blink_cnt;

    logic [4*N_DIGITS-1:0]   shadow_digits;
    logic [N_DIGITS-1:0]     shadow_dp;
    logic [N_DIGITS-1:0]     shadow_blank;
    logic [N_DIGITS-1:0]     shadow_blink;

    logic                    slot_end;
    logic                    frame_wrap;
    logic [PWM_BITS-1:0]     pwm_field;
    logic                    pwm_on;
    logic                    blink_phase;
    logic                    lit;

    // Shadow state widened to a full 8-digit view so the 3-bit index never
    // selects past the end of a narrower configuration.
    logic [3:0]              nib8 [0:7];
    logic [7:0]              dp8;
    logic [7:0]              blank8;
    logic [7:0]              blink8;
    logic [7:0]              an8;
    logic [6:0]              seg;

    assign slot_end    = &prescaler;
    assign frame_wrap  = slot_end && (digit_idx == 3'(N_DIGITS - 1));
    assign pwm_field   = prescaler[CLK_DIV_BITS-1 -: PWM_BITS];
    // All-ones brightness must be fully on; a plain compare would leave one step dark.
    assign pwm_on      = (&brightness) | (pwm_field < brightness);
    assign blink_phase = blink_cnt[BLINK_BITS-1];

    always_comb begin
        dp8    = '0;
        blank8 = '0;
        blink8 = '0;
        for (int i = 0; i < 8; i++) begin
            nib8[i] = 4'h0;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            nib8[i]   = shadow_digits[4*i +: 4];
            dp8[i]    = shadow_dp[i];
            blank8[i] = shadow_blank[i];
            blink8[i] = shadow_blink[i];
        end
    end

    assign lit = pwm_on & ~blank8[digit_idx] & ~(blink8[digit_idx] & blink_phase);

    // abcdefg, active-low
    always_comb begin
        seg = 7'b1111111;
        case (nib8[digit_idx])
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

    always_comb begin
        an8            = 8'hFF;
        an8[digit_idx] = ~lit;
    end

    // Free-running counters and frame sequencing
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prescaler  <= '0;
            blink_cnt  <= '0;
            digit_idx  <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            blink_cnt  <= blink_cnt + 1'b1;
            frame_done <= frame_wrap;
            if (frame_wrap) begin
                digit_idx <= 3'd0;
            end else if (slot_end) begin
                digit_idx <= digit_idx + 3'd1;
            end
        end
    end

    // Shadow registers only change on the wrap edge, so a frame is never torn.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            shadow_blink  <= '0;
        end else if (frame_wrap && update_en) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_blank  <= blank_in;
            shadow_blink  <= blink_in;
        end
    end

    // Registered pin drivers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            An       <= '1;
            Cathodes <= 8'hFF;
        end else begin
            An       <= an8[N_DIGITS-1:0];
            Cathodes <= lit ? {seg, ~dp8[digit_idx]} : 8'hFF;
        end
    end

endmodule

// File: tb/tb_nexys_starship_ssd_scanner.sv
module tb_nexys_starship_ssd_scanner;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic [1:0]  brightness;
    logic        update_en;
    logic [3:0]  An;
    logic [7:0]  Cathodes;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    nexys_starship_ssd_scanner #(
        .N_DIGITS(4), .CLK_DIV_BITS(4), .PWM_BITS(2), .BLINK_BITS(7)
    ) dut (
        .Clk(Clk), .Reset(Reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .brightness(brightness),
        .update_en(update_en), .An(An), .Cathodes(Cathodes),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    // cyc = number of rising edges since reset release; sampling is 1 time unit after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cnt_a, cnt_b;
    logic fd64, fd65;

    initial begin
        Reset = 1'b1; digits_in = 16'h0000; dp_in = 4'b0000; blank_in = 4'b0000;
        blink_in = 4'b0000; brightness = 2'd3; update_en = 1'b0;

        // 1. reset state and scan timing
        repeat (3) tick();
        check("rst_an", 32'(An), 32'hF);
        check("rst_cath", 32'(Cathodes), 32'hFF);
        check("rst_idx", 32'(digit_idx), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        Reset = 1'b0;
        cyc = 0;
        tick();
        check("first_frame_an", 32'(An), 32'b1110);
        check("first_frame_cath", 32'(Cathodes), 32'b00000011);
        run_to(15);
        check("idx_at_15", 32'(digit_idx), 32'd0);
        tick();
        check("idx_at_16", 32'(digit_idx), 32'd1);
        cnt_a = 0; fd64 = 1'b0; fd65 = 1'b1;
        while (cyc < 192) begin
            tick();
            if (frame_done) cnt_a++;
            if (cyc == 64) fd64 = frame_done;
            if (cyc == 65) fd65 = frame_done;
        end
        check("fd_pulses", 32'(cnt_a), 32'd3);
        check("fd_at_64", 32'(fd64), 32'd1);
        check("fd_at_65", 32'(fd65), 32'd0);

        // 2. decode after a frame-boundary load at edge 256
        run_to(200);
        digits_in = 16'h3A70; dp_in = 4'b0010; update_en = 1'b1;
        run_to(250);
        check("pre_load_an", 32'(An), 32'b0111);
        check("pre_load_cath", 32'(Cathodes), 32'b00000011);
        run_to(257);
        update_en = 1'b0;
        run_to(260);
        check("d0_an", 32'(An), 32'b1110);
        check("d0_cath", 32'(Cathodes), 32'b00000011);
        run_to(276);
        check("d1_an", 32'(An), 32'b1101);
        check("d1_cath", 32'(Cathodes), 32'b00011110);
        run_to(292);
        check("d2_an", 32'(An), 32'b1011);
        check("d2_cath", 32'(Cathodes), 32'b00010001);
        run_to(308);
        check("d3_an", 32'(An), 32'b0111);
        check("d3_cath", 32'(Cathodes), 32'b00001101);

        // 3. tear-free: mid-frame change, load only at edge 384
        run_to(330);
        digits_in = 16'h1234; update_en = 1'b1;
        run_to(340);
        check("tear_d1_cath", 32'(Cathodes), 32'b00011110);
        run_to(372);
        check("tear_d3_cath", 32'(Cathodes), 32'b00001101);
        run_to(384);
        check("tear_fd", 32'(frame_done), 32'd1);
        run_to(390);
        check("new_d0_an", 32'(An), 32'b1110);
        check("new_d0_cath", 32'(Cathodes), 32'b10011001);
        update_en = 1'b0; digits_in = 16'h0000;
        run_to(470);
        check("hold_d1_an", 32'(An), 32'b1101);
        check("hold_d1_cath", 32'(Cathodes), 32'b00001100);
        run_to(600);
        check("hold2_d1_cath", 32'(Cathodes), 32'b00001100);

        // 4a. blank digit 2, loaded at edge 640
        run_to(610);
        blank_in = 4'b0100; update_en = 1'b1;
        run_to(641);
        update_en = 1'b0;
        run_to(641);
        cnt_a = 0; cnt_b = 0;
        while (cyc < 769) begin
            tick();
            if (!An[2]) cnt_a++;
            if (!An[1]) cnt_b++;
        end
        check("blank_an2_low", 32'(cnt_a), 32'd0);
        check("blank_an1_low", 32'(cnt_b), 32'd32);

        // 4b. blink digit 0, loaded at edge 832
        run_to(770);
        blank_in = 4'b0000; blink_in = 4'b0001; update_en = 1'b1;
        run_to(833);
        update_en = 1'b0;
        cnt_a = 0;
        while (cyc < 1089) begin
            tick();
            if (!An[0]) cnt_a++;
        end
        check("blink_an0_low", 32'(cnt_a), 32'd32);
        // spot checks one period later: blink counter 1 -> lit, 65 -> dark
        run_to(1090);
        blink_in = 4'b0000; digits_in = 16'h5555; update_en = 1'b1;
        run_to(1153);
        update_en = 1'b0;

        // 5. PWM
        run_to(1160);
        brightness = 2'd1;
        run_to(1169);
        check("pwm1_on_an", 32'(An), 32'b1101);
        check("pwm1_on_cath", 32'(Cathodes), 32'b01001000);
        cnt_a = (An[1] == 1'b0) ? 1 : 0;
        while (cyc < 1184) begin
            tick();
            if (!An[1]) cnt_a++;
            if (cyc == 1173) check("pwm1_off_an", 32'(An), 32'b1111);
        end
        check("pwm1_slot_cnt", 32'(cnt_a), 32'd4);
        run_to(1280);
        brightness = 2'd2;
        run_to(1281);
        cnt_a = 0;
        while (cyc < 1345) begin
            tick();
            if (An != 4'b1111) cnt_a++;
        end
        check("pwm2_frame_cnt", 32'(cnt_a), 32'd32);
        run_to(1346);
        brightness = 2'd0;
        run_to(1347);
        cnt_a = 0; cnt_b = 0;
        while (cyc < 1411) begin
            tick();
            if (An != 4'b1111) cnt_a++;
            if (Cathodes != 8'hFF) cnt_b++;
        end
        check("pwm0_an_cnt", 32'(cnt_a), 32'd0);
        check("pwm0_cath_cnt", 32'(cnt_b), 32'd0);

        // 6. mid-frame reset
        run_to(1412);
        brightness = 2'd3;
        run_to(1445);
        check("pre_rst_idx", 32'(digit_idx), 32'd2);
        check("pre_rst_cath", 32'(Cathodes), 32'b01001001);
        Reset = 1'b1;
        #1;
        check("midrst_an", 32'(An), 32'hF);
        check("midrst_cath", 32'(Cathodes), 32'hFF);
        check("midrst_idx", 32'(digit_idx), 32'd0);
        repeat (2) tick();
        Reset = 1'b0;
        cyc = 0;
        tick();
        check("post_rst_an", 32'(An), 32'b1110);
        check("post_rst_cath", 32'(Cathodes), 32'b00000011);
        run_to(16);
        check("post_rst_idx16", 32'(digit_idx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nexys_starship_ssd_scanner.md
Name: nexys_starship_ssd_scanner

Overview:
Parametrised seven-segment display scan controller for the Nexys-4 board. It replaces the hard-wired 8-digit scan mux and hex-to-SSD decoder in the starship top level. Added features over the hard-wired logic:
- configurable digit count and scan rate
- tear-free shadow loading at frame boundaries
- per-digit blanking and blinking
- PWM brightness control
It sits between the game state machines and the An/Ca..Cg/Dp pins.

Parameters:
N_DIGITS, 8, number of digits scanned (1..8 legal).
CLK_DIV_BITS, 14, each digit slot lasts 2^CLK_DIV_BITS Clk cycles.
PWM_BITS, 4, brightness resolution; must be <= CLK_DIV_BITS.
BLINK_BITS, 25, blink period is 2^BLINK_BITS Clk cycles, 50% duty.

Ports:
Clk  in  1  system clock (100 MHz)
Reset  in  1  asynchronous, active-high reset
digits_in  in  4*N_DIGITS  hex nibble per digit; digit k = [4k+3:4k]
dp_in  in  N_DIGITS  1 = light decimal point of digit k
blank_in  in  N_DIGITS  1 = digit k dark
blink_in  in  N_DIGITS  1 = digit k blinks
brightness  in  PWM_BITS  duty select; 0 = dark, all-ones = full on
update_en  in  1  1 = shadow registers reload at the next frame boundary
An  out  N_DIGITS  anodes, active-low
Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
digit_idx  out  3  index of the digit currently in its slot
frame_done  out  1  one-cycle pulse at the end of the last digit slot

Behaviour:
- Reset values (asynchronous, while Reset=1):
  - prescaler=0, digit_idx=0, blink counter=0
  - shadow digits/dp/blank/blink=0
  - An=all ones, Cathodes=8'hFF, frame_done=0
- Prescaler:
  - CLK_DIV_BITS-wide counter, increments every Clk and wraps to 0.
  - slot_end is asserted when prescaler = all-ones.
- Digit index:
  - On slot_end, digit_idx increments.
  - If digit_idx = N_DIGITS-1, it wraps to 0 instead, and frame_done = 1 on the following cycle only.
- Shadow load:
  - On a wrap cycle (slot_end with digit_idx = N_DIGITS-1), if update_en=1 that same cycle, shadow regs <= digits_in/dp_in/blank_in/blink_in.
  - Otherwise shadow regs hold.
  - Inputs changing mid-frame never alter the displayed frame.
  - First frame after reset displays zeros with blank=0. Reset state itself is dark because of the registered outputs.
- PWM:
  - pwm_field = prescaler[CLK_DIV_BITS-1 : CLK_DIV_BITS-PWM_BITS].
  - pwm_on = 1 if brightness = all-ones; otherwise pwm_on = (pwm_field < brightness).
  - brightness is sampled live, not shadowed.
- Blink: blink_phase = blink counter MSB. A digit with shadow blink=1 is dark while blink_phase=1.
- Digit enable: lit = pwm_on & ~shadow_blank[idx] & ~(shadow_blink[idx] & blink_phase).
- Outputs are registered, with one Clk latency from the internal state.
  - An: bit idx = ~lit; all other bits = 1. Exactly one anode is low at most.
  - Cathodes when lit: {seg(nibble), ~shadow_dp[idx]}.
  - Cathodes when not lit: 8'hFF.
- seg table (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-frame: immediate return to digit 0 and dark outputs; scanning resumes from digit 0 on the first edge after release.
- No state machine beyond the counters; all counters are free-running.

Test Plan:
Test configuration: N_DIGITS=4, CLK_DIV_BITS=4, PWM_BITS=2, BLINK_BITS=7.
1. Reset: Reset=1 for 3 cycles -> An=4'b1111, Cathodes=8'hFF, digit_idx=0, frame_done=0. After release, digit_idx becomes 1 after 16 cycles, and frame_done pulses once every 64 cycles.
2. Decode: digits_in=16'h3A70, dp_in=4'b0010, brightness=3, update_en=1 over one frame boundary. The next frame must show:
   - digit0: An=1110, Cathodes=8'b00000011
   - digit1: An=1101, Cathodes=8'b00011110
   - digit2: An=1011, Cathodes=8'b00010001
   - digit3: An=0111, Cathodes=8'b00001101
3. Tear-free: change digits_in mid-frame with update_en=1 -> the displayed frame is unchanged until after the next frame_done. With update_en=0 at the boundary, the old values persist indefinitely.
4. Blank/blink: blank_in=4'b0100 -> An[2] is never low. blink_in=4'b0001 -> An[0] is low only while blink counter bit 6 = 0, giving a 64-cycle on/64-cycle off pattern.
5. PWM: brightness=1 -> each digit is lit 4 of its 16 slot cycles. brightness=2 -> 8 of 16. brightness=0 -> An stays all ones.
6. Mid-frame reset: assert Reset while digit_idx=2 -> outputs dark immediately. After release, scanning restarts at digit 0, and the shadow shows digit 0 with value 0.
